// File: rtl/thermal_trip_monitor.sv
// Purpose : debounced, hysteretic overheat flag with sensor-stale watchdog fail-safe
//           and a saturating trip counter.
// Latency : one clock from the qualifying sample (or watchdog expiry) to the registered outputs.
// Backpressure: none; temp_valid is a strobe and every sample is consumed when it arrives.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high; returns every register to its idle value
//   temp_valid     temp carries a new sample this cycle
//   temp           unsigned temperature sample, TEMP_W bits
//   clear_trip     one-cycle pulse that releases the sticky trip latch (sticky build only)
//   cpu_overheated registered overheat flag to the shutdown logic
//   sensor_stale   registered; no valid sample for TIMEOUT cycles
//   trip_count     number of HOT entries from the cool side, saturating at 255
//   state          FSM state: COOL=0, ARMING=1, HOT=2, COOLING=3
//
// Build option: define THERMAL_STICKY_EN to hold cpu_overheated after a trip until
// clear_trip is pulsed while the FSM is back in COOL.

module thermal_trip_monitor #(
    parameter int TEMP_W      = 8,
    parameter int HOT_THRESH  = 90,
    parameter int COOL_THRESH = 80,
    parameter int DEBOUNCE    = 4,
    parameter int TIMEOUT     = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              temp_valid,
    input  logic [TEMP_W-1:0] temp,
    input  logic              clear_trip,
    output logic              cpu_overheated,
    output logic              sensor_stale,
    output logic [7:0]        trip_count,
    output logic [1:0]        state
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    localparam logic [3:0]        DEB    = 4'(DEBOUNCE);
    localparam logic [WD_W-1:0]   WD_MAX = WD_W'(TIMEOUT);
    localparam logic [TEMP_W-1:0] HOT_T  = TEMP_W'(HOT_THRESH);
    localparam logic [TEMP_W-1:0] COOL_T = TEMP_W'(COOL_THRESH);

    typedef enum logic [1:0] {
        ST_COOL    = 2'd0,
        ST_ARMING  = 2'd1,
        ST_HOT     = 2'd2,
        ST_COOLING = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [7:0]      trip_d;
    logic            stale_d;
    logic            flag_d;
    logic            samp_hot, samp_cool;
    logic            trip_entry;   // HOT entered from COOL or ARMING
    logic            hot_enter;    // HOT entered from any other state

    assign samp_hot  = temp_valid && (temp >= HOT_T);
    assign samp_cool = temp_valid && (temp <= COOL_T);

    // FSM only advances on a valid sample. A stale sensor by definition has delivered
    // no valid sample, so state and debounce count stay frozen while stale, and the
    // sample that ends the stale period is classified normally.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        trip_entry = 1'b0;
        if (temp_valid) begin
            case (state_q)
                ST_COOL: begin
                    if (samp_hot) begin
                        if (DEB == 4'd1) begin
                            state_d    = ST_HOT;
                            cnt_d      = 4'd0;
                            trip_entry = 1'b1;
                        end else begin
                            state_d = ST_ARMING;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                ST_ARMING: begin
                    if (samp_hot) begin
                        if (cnt_q + 4'd1 == DEB) begin
                            state_d    = ST_HOT;
                            cnt_d      = 4'd0;
                            trip_entry = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else begin
                        state_d = ST_COOL;
                        cnt_d   = 4'd0;
                    end
                end
                ST_HOT: begin
                    if (samp_cool) begin
                        if (DEB == 4'd1) begin
                            state_d = ST_COOL;
                            cnt_d   = 4'd0;
                        end else begin
                            state_d = ST_COOLING;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                ST_COOLING: begin
                    if (samp_cool) begin
                        if (cnt_q + 4'd1 == DEB) begin
                            state_d = ST_COOL;
                            cnt_d   = 4'd0;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else if (samp_hot) begin
                        // Re-heat during cool-down: back to HOT without counting a new trip.
                        state_d = ST_HOT;
                        cnt_d   = 4'd0;
                    end
                end
                default: begin
                    state_d = ST_COOL;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    assign hot_enter = (state_d == ST_HOT) && (state_q != ST_HOT);

    // Watchdog: cycles since the last valid sample, parked at TIMEOUT.
    always_comb begin
        if (temp_valid) begin
            wd_d = '0;
        end else if (wd_q == WD_MAX) begin
            wd_d = wd_q;
        end else begin
            wd_d = wd_q + 1'b1;
        end
    end

    assign stale_d = (wd_d == WD_MAX);
    assign trip_d  = (trip_entry && (trip_count != 8'hFF)) ? trip_count + 8'd1 : trip_count;

`ifdef THERMAL_STICKY_EN
    logic latch_q, latch_d;

    // A trip in the same cycle outranks the clear, so hot_enter is tested first.
    always_comb begin
        latch_d = latch_q;
        if (hot_enter) begin
            latch_d = 1'b1;
        end else if (clear_trip && (state_q == ST_COOL)) begin
            latch_d = 1'b0;
        end
    end

    assign flag_d = latch_d || stale_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            latch_q <= 1'b0;
        end else begin
            latch_q <= latch_d;
        end
    end
`else
    logic unused_clear;
    logic unused_enter;
    assign unused_clear = clear_trip;
    assign unused_enter = hot_enter;
    assign flag_d = (state_d == ST_HOT) || (state_d == ST_COOLING) || stale_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_COOL;
            cnt_q          <= 4'd0;
            wd_q           <= '0;
            trip_count     <= 8'd0;
            sensor_stale   <= 1'b0;
            cpu_overheated <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            wd_q           <= wd_d;
            trip_count     <= trip_d;
            sensor_stale   <= stale_d;
            cpu_overheated <= flag_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_thermal_trip_monitor.sv
// Purpose : self-checking bench for thermal_trip_monitor (directed test-plan scenarios
//           followed by randomized traffic against a behavioural reference model).
// Latency : outputs compared on the falling edge after each rising edge.
// Backpressure: not applicable.

module tb_thermal_trip_monitor;

    localparam int TO = 8;
    localparam int D  = 4;
    localparam int HT = 90;
    localparam int CT = 80;

    logic       clk = 1'b0;
    logic       reset;
    logic       temp_valid;
    logic [7:0] temp;
    logic       clear_trip;
    logic       cpu_overheated;
    logic       sensor_stale;
    logic [7:0] trip_count;
    logic [1:0] state;

    always #5 clk = ~clk;

    thermal_trip_monitor #(
        .TEMP_W(8), .HOT_THRESH(HT), .COOL_THRESH(CT), .DEBOUNCE(D), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .temp_valid(temp_valid),
        .temp(temp),
        .clear_trip(clear_trip),
        .cpu_overheated(cpu_overheated),
        .sensor_stale(sensor_stale),
        .trip_count(trip_count),
        .state(state)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: which side of the hysteresis band we are on, plus the length
    // of the current run of samples pushing toward the other side.
    bit m_hot_side;
    int m_streak;
    int m_trips;
    int m_idle;
    bit m_latch;

    function automatic int m_state();
        if (m_hot_side) return (m_streak > 0) ? 3 : 2;
        return (m_streak > 0) ? 1 : 0;
    endfunction

    function automatic int m_flag();
        bit stale;
        stale = (m_idle == TO);
`ifdef THERMAL_STICKY_EN
        return int'(m_latch || stale);
`else
        return int'(m_hot_side || stale);
`endif
    endfunction

    task automatic model_step(input bit rst, input bit v, input int t, input bit clr);
        int  prev;
        bit  entered;
        bit  hot;
        bit  cool;
        if (rst) begin
            m_hot_side = 0; m_streak = 0; m_trips = 0; m_idle = 0; m_latch = 0;
            return;
        end
        prev    = m_state();
        entered = 0;
        hot     = (t >= HT);
        cool    = (t <= CT);
        if (v) m_idle = 0;
        else if (m_idle < TO) m_idle++;
        if (v) begin
            if (!m_hot_side) begin
                if (hot) begin
                    m_streak++;
                    if (m_streak >= D) begin
                        m_hot_side = 1;
                        m_streak   = 0;
                        entered    = 1;
                        if (m_trips < 255) m_trips++;
                    end
                end else begin
                    m_streak = 0;
                end
            end else begin
                if (cool) begin
                    m_streak++;
                    if (m_streak >= D) begin
                        m_hot_side = 0;
                        m_streak   = 0;
                    end
                end else if (hot) begin
                    if (m_streak > 0) entered = 1;
                    m_streak = 0;
                end
            end
        end
        if (entered) m_latch = 1;
        else if (clr && prev == 0) m_latch = 0;
    endtask

    task automatic step(input bit rst, input bit v, input int t, input bit clr);
        reset      = rst;
        temp_valid = v;
        temp       = 8'(t);
        clear_trip = clr;
        @(posedge clk);
        model_step(rst, v, t, clr);
        @(negedge clk);
        check("state",    int'(state),          m_state());
        check("trips",    int'(trip_count),     m_trips);
        check("stale",    int'(sensor_stale),   int'(m_idle == TO));
        check("overheat", int'(cpu_overheated), m_flag());
    endtask

    task automatic feed(input int t, input int n);
        for (int i = 0; i < n; i++) step(0, 1, t, 0);
    endtask

    initial begin
        reset = 1; temp_valid = 0; temp = 0; clear_trip = 0;
        step(1, 0, 0, 0);
        step(1, 1, 99, 1);
        check("rst_state", int'(state), 0);
        check("rst_flag",  int'(cpu_overheated), 0);

        // Hysteresis trip
        feed(95, 3);
        check("arming_no_flag", int'(cpu_overheated), 0);
        feed(95, 1);
        check("trip_flag",  int'(cpu_overheated), 1);
        check("trip_state", int'(state), 2);
        check("trip_count", int'(trip_count), 1);
        feed(85, 10);
        check("neutral_hold", int'(state), 2);

        // Cool-down interrupted by re-heat, then full cool-down
        feed(70, 2);
        check("cooling_state", int'(state), 3);
        feed(95, 1);
        check("reheat_state", int'(state), 2);
        check("reheat_trips", int'(trip_count), 1);
        feed(70, 3);
        check("cooling_flag", int'(cpu_overheated), 1);
        feed(70, 1);
        check("cooled_flag",  int'(cpu_overheated), 0);
        check("cooled_state", int'(state), 0);

        // Interrupted arming
        feed(95, 3);
        feed(85, 1);
        check("abort_state", int'(state), 0);
        feed(95, 1);
        check("abort_flag", int'(cpu_overheated), 0);
        feed(70, 1);

        // Watchdog
        for (int i = 0; i < TO - 1; i++) step(0, 0, 0, 0);
        check("pre_stale", int'(sensor_stale), 0);
        step(0, 0, 0, 0);
        check("stale_on",  int'(sensor_stale), 1);
        check("stale_flg", int'(cpu_overheated), 1);
        step(0, 0, 0, 0);
        feed(50, 1);
        check("stale_off", int'(sensor_stale), 0);
        check("stale_flg_off", int'(cpu_overheated), 0);

        // Trip, then clear attempts (only effective in the sticky build)
        feed(95, 4);
        step(0, 0, 0, 1);
        check("clr_in_hot", int'(cpu_overheated), 1);
        feed(70, 4);
        check("cool_after_trip", int'(state), 0);
`ifdef THERMAL_STICKY_EN
        check("sticky_hold", int'(cpu_overheated), 1);
        step(0, 0, 0, 1);
        check("sticky_clear", int'(cpu_overheated), 0);
`else
        step(0, 0, 0, 1);
        check("no_sticky", int'(cpu_overheated), 0);
`endif

        // Trip counter saturation
        for (int k = 0; k < 256; k++) begin
            feed(95, 4);
            feed(70, 4);
        end
        check("sat_trips", int'(trip_count), 255);
        feed(95, 3);
        check("arming3", int'(state), 1);
        step(1, 1, 95, 0);
        check("rst_mid_state", int'(state), 0);
        check("rst_mid_trips", int'(trip_count), 0);
        check("rst_mid_flag",  int'(cpu_overheated), 0);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            int  t;
            bit  v;
            bit  clr;
            bit  rst;
            if ($urandom_range(0, 199) == 0) begin
                for (int g = 0; g < TO + 2; g++) step(0, 0, 0, $urandom_range(0, 9) == 0);
            end
            v   = ($urandom_range(0, 9) < 8);
            t   = ($urandom_range(0, 1) == 0) ? int'($urandom_range(75, 95)) : int'($urandom_range(0, 255));
            clr = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step(rst, v, t, clr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
